multicycle_control_unit: RTL and testbench

Parametrised multi-cycle controller for the course CPU datapath. It sequences fetch, decode, execute, memory and writeback.
- Drives register-file, ALU and RAM control signals.
- Runs the MFA/MFC RAM handshake with a timeout.
- Services non-maskable and maskable interrupts at instruction boundaries.
- Holds the PC internally. Sits between the RAM, the register file and the ALU.

---
 rtl/multicycle_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with MFA/MFC RAM handshake, bus timeout and interrupts.
// Interrupts are taken only on the first FETCH cycle of an instruction; ERROR is sticky until reset.
module multicycle_control_unit #(
  parameter int              ADDR_W      = 9,
  parameter int              REG_W       = 5,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] NMI_VECTOR = 9'h100,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = 9'h180,
  parameter int              MFC_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic              ramMFC,
  input  logic              hardwareInterrupt,
  input  logic              maskableInterrupt,
  input  logic              intEnable,
  output logic              regFileRW,
  output logic [REG_W-1:0]  regFileRD,
  output logic [REG_W-1:0]  regFileRS,
  output logic [REG_W-1:0]  regFileRT,
  output logic [1:0]        aluSign,
  output logic [3:0]        aluOperation,
  output logic [1:0]        ramDataSize,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic              irqAck,
  output logic              busError
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, INT, ERROR} state_t;

  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

  state_t            state, nxt;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_q, epc_q, addr_q;
  logic              chk_q, chk_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              int_req, mfa;

  // Decoded view of the latched instruction, stable from DECODE through WB.
  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] f_rs, f_rt, f_rd;
  logic             dec_wb, dec_load, dec_store;
  logic [3:0]       dec_op;
  logic [1:0]       dec_sign, dec_size;
  logic [REG_W-1:0] dec_dest;
  logic             unused_shamt;

  assign opcode       = instr_q[31:26];
  assign funct        = instr_q[5:0];
  assign f_rs         = REG_W'(instr_q[25:21]);
  assign f_rt         = REG_W'(instr_q[20:16]);
  assign f_rd         = REG_W'(instr_q[15:11]);
  assign unused_shamt = ^instr_q[10:6];

  always_comb begin
    dec_wb    = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_op    = 4'd0;
    dec_sign  = 2'b00;
    dec_size  = 2'b00;
    dec_dest  = '0;
    case (opcode)
      6'h00: begin
        dec_dest = f_rd;
        case (funct)
          6'h20: begin dec_wb = 1'b1; dec_op = 4'd0; dec_sign = 2'b01; end
          6'h22: begin dec_wb = 1'b1; dec_op = 4'd1; dec_sign = 2'b01; end
          6'h24: begin dec_wb = 1'b1; dec_op = 4'd2; dec_sign = 2'b00; end
          6'h25: begin dec_wb = 1'b1; dec_op = 4'd3; dec_sign = 2'b00; end
          6'h2A: begin dec_wb = 1'b1; dec_op = 4'd4; dec_sign = 2'b01; end
          default: ;
        endcase
      end
      6'h08: begin dec_wb = 1'b1; dec_sign = 2'b01; dec_dest = f_rt; end
      6'h20: begin dec_load = 1'b1; dec_sign = 2'b01; dec_size = 2'b00; dec_dest = f_rt; end
      6'h21: begin dec_load = 1'b1; dec_sign = 2'b01; dec_size = 2'b01; dec_dest = f_rt; end
      6'h23: begin dec_load = 1'b1; dec_sign = 2'b01; dec_size = 2'b10; dec_dest = f_rt; end
      6'h28: begin dec_store = 1'b1; dec_sign = 2'b01; dec_size = 2'b00; end
      6'h29: begin dec_store = 1'b1; dec_sign = 2'b01; dec_size = 2'b01; end
      6'h2B: begin dec_store = 1'b1; dec_sign = 2'b01; dec_size = 2'b10; end
      default: ;
    endcase
  end

  assign int_req = hardwareInterrupt | (maskableInterrupt & intEnable);

  always_comb begin
    nxt          = state;
    mfa          = 1'b0;
    cnt_nxt      = '0;
    regFileRW    = 1'b0;
    regFileRD    = '0;
    regFileRS    = '0;
    regFileRT    = '0;
    aluSign      = 2'b00;
    aluOperation = 4'd0;
    ramDataSize  = 2'b00;
    ramMFA       = 1'b0;
    ramRW        = 1'b0;
    ramAddress   = '0;
    irqAck       = 1'b0;
    busError     = 1'b0;
    case (state)
      FETCH: begin
        if (chk_q && int_req) begin
          nxt = INT;
        end else begin
          mfa         = 1'b1;
          ramMFA      = 1'b1;
          ramDataSize = 2'b10;
          ramAddress  = pc_q;
          // MFC on the final allowed wait cycle still wins over the timeout.
          if (ramMFC)                                    nxt = DECODE;
          else if (cnt_q == CNT_W'(MFC_TIMEOUT - 1))     nxt = ERROR;
          else                                           cnt_nxt = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        regFileRS = f_rs;
        regFileRT = f_rt;
        nxt       = EXEC;
      end
      EXEC: begin
        regFileRS    = f_rs;
        regFileRT    = f_rt;
        aluOperation = dec_op;
        aluSign      = dec_sign;
        if (dec_load || dec_store) nxt = MEM;
        else if (dec_wb)           nxt = WB;
        else                       nxt = FETCH;
      end
      MEM: begin
        mfa         = 1'b1;
        regFileRS   = f_rs;
        regFileRT   = f_rt;
        ramMFA      = 1'b1;
        ramRW       = dec_store;
        ramDataSize = dec_size;
        ramAddress  = addr_q;
        if (ramMFC)                                    nxt = dec_load ? WB : FETCH;
        else if (cnt_q == CNT_W'(MFC_TIMEOUT - 1))     nxt = ERROR;
        else                                           cnt_nxt = cnt_q + 1'b1;
      end
      WB: begin
        regFileRD = dec_dest;
        regFileRW = (dec_dest != '0);
        nxt       = FETCH;
      end
      INT: begin
        irqAck = 1'b1;
        nxt    = FETCH;
      end
      ERROR: busError = 1'b1;
      default: nxt = ERROR;
    endcase
    // Returning from INT skips the interrupt check so the handler's first instruction is fetched.
    chk_nxt = (nxt == FETCH) && (state != FETCH) && (state != INT);
    if (!reset) begin
      regFileRW    = 1'b0;
      regFileRD    = '0;
      regFileRS    = '0;
      regFileRT    = '0;
      aluSign      = 2'b00;
      aluOperation = 4'd0;
      ramDataSize  = 2'b00;
      ramMFA       = 1'b0;
      ramRW        = 1'b0;
      ramAddress   = '0;
      irqAck       = 1'b0;
      busError     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      chk_q   <= 1'b1;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      state <= nxt;
      chk_q <= chk_nxt;
      cnt_q <= cnt_nxt;
      if (state == FETCH && mfa && ramMFC) instr_q <= instruction;
      if (state == EXEC)                   addr_q  <= aluResult;
      if (state == DECODE)                 pc_q    <= pc_q + ADDR_W'(4);
      if (nxt == INT) begin
        epc_q <= pc_q;
        pc_q  <= hardwareInterrupt ? NMI_VECTOR : IRQ_VECTOR;
      end
    end
  end

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: register writes and interrupt entries are
// scoreboarded (expected on stimulus, popped when the DUT pulses regFileRW / irqAck).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [8:0]  aluResult;
  logic        ramMFC, hardwareInterrupt, maskableInterrupt, intEnable;
  logic        regFileRW;
  logic [4:0]  regFileRD, regFileRS, regFileRT;
  logic [1:0]  aluSign;
  logic [3:0]  aluOperation;
  logic [1:0]  ramDataSize;
  logic        ramMFA, ramRW;
  logic [8:0]  ramAddress, pc, epc;
  logic        irqAck, busError;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .aluResult(aluResult),
    .ramMFC(ramMFC), .hardwareInterrupt(hardwareInterrupt),
    .maskableInterrupt(maskableInterrupt), .intEnable(intEnable),
    .regFileRW(regFileRW), .regFileRD(regFileRD), .regFileRS(regFileRS),
    .regFileRT(regFileRT), .aluSign(aluSign), .aluOperation(aluOperation),
    .ramDataSize(ramDataSize), .ramMFA(ramMFA), .ramRW(ramRW),
    .ramAddress(ramAddress), .pc(pc), .epc(epc), .irqAck(irqAck), .busError(busError)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [8:0]  exp_pc;
  bit          mid_ie   = 1'b0;
  logic [4:0]  wb_q[$];
  logic [17:0] irq_q[$];

  localparam logic [31:0] NOP = 32'hFC00_0000;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Scoreboard consumers.
  always @(negedge clk) begin
    if (regFileRW) begin
      n_assert++;
      assert (wb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed rd %0d expected no write", regFileRD);
      end
      if (wb_q.size() > 0) begin
        automatic logic [4:0] e = wb_q.pop_front();
        n_assert++;
        assert (regFileRD === e) else begin
          n_fail++;
          $error("FAIL wb_rd: observed %0d expected %0d", regFileRD, e);
        end
      end
    end
    if (irqAck) begin
      n_assert++;
      assert (irq_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_irqack: observed epc %0h pc %0h expected none", epc, pc);
      end
      if (irq_q.size() > 0) begin
        automatic logic [17:0] e = irq_q.pop_front();
        n_assert++;
        assert ({epc, pc} === e) else begin
          n_fail++;
          $error("FAIL irq_entry: observed epc/pc %0h/%0h expected %0h/%0h", epc, pc, e[17:9], e[8:0]);
        end
      end
    end
  end

  // kind: 0 ALU writeback, 1 load, 2 store, 3 NOP. Called and returns on a FETCH-cycle negedge.
  task automatic instr(input logic [31:0] ins, input int fw, input int rs, input int rt,
                       input int op, input int sign, input int kind, input int rd,
                       input logic [8:0] addr, input int size, input int mw,
                       input bit abort, input int exp_cyc);
    int c0;
    c0 = cyc;
    #1;
    check("fetch_mfa", ramMFA, 1);
    check("fetch_addr", ramAddress, exp_pc);
    check("fetch_size", ramDataSize, 2);
    check("fetch_rw", ramRW, 0);
    repeat (fw) @(negedge clk);
    if (fw > 0) check("fetch_wait_mfa", ramMFA, 1);
    ramMFC = 1'b1; instruction = ins;
    @(negedge clk);
    ramMFC = 1'b0; instruction = 32'hFFFF_FFFF;
    check("dec_mfa", ramMFA, 0);
    check("dec_rs", regFileRS, rs);
    check("dec_rt", regFileRT, rt);
    if (mid_ie) intEnable = 1'b1;
    if ((kind == 0 || kind == 1) && rd != 0 && !abort) wb_q.push_back(5'(rd));
    exp_pc = exp_pc + 9'd4;
    @(negedge clk);
    check("exec_pc", pc, exp_pc);
    if (kind != 3) begin
      check("exec_op", aluOperation, op);
      check("exec_sign", aluSign, sign);
    end
    aluResult = addr;
    @(negedge clk);
    if (kind == 1 || kind == 2) begin
      aluResult = 9'h000;
      check("mem_mfa", ramMFA, 1);
      check("mem_addr", ramAddress, addr);
      check("mem_rw", ramRW, kind == 2);
      check("mem_size", ramDataSize, size);
      if (abort) begin
        reset = 1'b0;
        #1;
        check("abort_mfa", ramMFA, 0);
        check("abort_rw", regFileRW, 0);
        check("abort_addr", ramAddress, 0);
        check("abort_ramrw", ramRW, 0);
        check("abort_size", ramDataSize, 0);
        check("abort_rs", regFileRS, 0);
        check("abort_pc", pc, 0);
        check("abort_epc", epc, 0);
        return;
      end
      repeat (mw) @(negedge clk);
      if (mw > 0) check("mem_addr_hold", ramAddress, addr);
      ramMFC = 1'b1;
      @(negedge clk);
      ramMFC = 1'b0;
    end
    if (kind == 0 || kind == 1) begin
      check("wb_rw", regFileRW, rd != 0);
      check("wb_pc", pc, exp_pc);
      @(negedge clk);
    end
    check("rw_pulse_end", regFileRW, 0);
    if (exp_cyc > 0) check("instr_cycles", cyc - c0, exp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; instruction = '0; aluResult = '0; ramMFC = 1'b0;
    hardwareInterrupt = 1'b0; maskableInterrupt = 1'b0; intEnable = 1'b0;
    exp_pc = 9'h000;
    repeat (2) @(negedge clk);
    check("rst_mfa", ramMFA, 0);
    check("rst_pc", pc, 0);
    check("rst_epc", epc, 0);
    check("rst_buserr", busError, 0);
    check("rst_irqack", irqAck, 0);
    check("rst_rw", regFileRW, 0);
    check("rst_addr", ramAddress, 0);
    check("rst_size", ramDataSize, 0);
    reset = 1'b1;

    // ALU and memory instructions, including MFC on the last allowed wait cycle.
    instr(32'h0085_1020, 2, 4, 5, 0, 1, 0, 2, 9'h000, 0, 0, 0, 6);
    instr(32'h8C83_0008, 0, 4, 3, 0, 1, 1, 3, 9'h010, 2, 2, 0, 7);
    instr(32'hA0A1_0000, 0, 5, 1, 0, 1, 2, 0, 9'h033, 0, 0, 0, 4);
    instr(rtype(5, 6, 0, 6'h20), 0, 5, 6, 0, 1, 0, 0, 9'h000, 0, 0, 0, 4);
    instr(rtype(1, 2, 3, 6'h22), 1, 1, 2, 1, 1, 0, 3, 9'h000, 0, 0, 0, 5);
    instr(rtype(7, 8, 9, 6'h24), 0, 7, 8, 2, 0, 0, 9, 9'h000, 0, 0, 0, 4);
    instr(rtype(10, 11, 12, 6'h25), 15, 10, 11, 3, 0, 0, 12, 9'h000, 0, 0, 0, 19);
    instr(rtype(13, 14, 15, 6'h2A), 0, 13, 14, 4, 1, 0, 15, 9'h000, 0, 0, 0, 4);
    instr(itype(6'h21, 2, 6, 16'h0), 0, 2, 6, 0, 1, 1, 6, 9'h1F0, 1, 15, 0, 20);
    instr(itype(6'h20, 3, 7, 16'h0), 0, 3, 7, 0, 1, 1, 7, 9'h0A1, 0, 0, 0, 5);
    instr(itype(6'h29, 4, 8, 16'h0), 0, 4, 8, 0, 1, 2, 0, 9'h0A2, 1, 1, 0, 5);
    instr(itype(6'h2B, 5, 9, 16'h0), 0, 5, 9, 0, 1, 2, 0, 9'h0A4, 2, 0, 0, 4);

    // Masked request is ignored; enabling it mid-instruction defers entry to the next FETCH.
    maskableInterrupt = 1'b1; intEnable = 1'b0;
    instr(NOP, 0, 0, 0, 0, 0, 3, 0, 9'h000, 0, 0, 0, 3);
    mid_ie = 1'b1;
    instr(NOP, 0, 0, 0, 0, 0, 3, 0, 9'h000, 0, 0, 0, 3);
    mid_ie = 1'b0;
    #1;
    check("irq_entry_mfa", ramMFA, 0);
    ramMFC = 1'b1;
    irq_q.push_back({exp_pc, 9'h180});
    @(negedge clk);
    ramMFC = 1'b0;
    check("irq_ack", irqAck, 1);
    check("irq_pc", pc, 9'h180);
    @(negedge clk);
    #1;
    check("irq_no_recheck_mfa", ramMFA, 1);
    check("irq_ack_pulse", irqAck, 0);
    maskableInterrupt = 1'b0; intEnable = 1'b0;
    exp_pc = 9'h180;

    // Walk to 0x1FC and confirm the PC wraps.
    for (int i = 0; i < 31; i++) instr(NOP, 0, 0, 0, 0, 0, 3, 0, 9'h000, 0, 0, 0, 3);
    check("pre_wrap_pc", pc, 9'h1FC);
    instr(itype(6'h08, 1, 9, 16'h5), 0, 1, 9, 0, 1, 0, 9, 9'h000, 0, 0, 0, 4);
    check("wrap_pc", pc, 9'h000);

    // Simultaneous requests: NMI wins.
    hardwareInterrupt = 1'b1; maskableInterrupt = 1'b1; intEnable = 1'b1;
    #1;
    check("nmi_entry_mfa", ramMFA, 0);
    irq_q.push_back({9'h000, 9'h100});
    @(negedge clk);
    check("nmi_pc", pc, 9'h100);
    check("nmi_epc", epc, 9'h000);
    hardwareInterrupt = 1'b0; maskableInterrupt = 1'b0; intEnable = 1'b0;
    @(negedge clk);
    exp_pc = 9'h100;

    // Reset asserted while the load is waiting in MEM.
    instr(itype(6'h23, 3, 4, 16'h0), 0, 3, 4, 0, 1, 1, 4, 9'h055, 2, 0, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 9'h000;

    // Fetch timeout after 16 wait cycles, then ERROR is sticky and deaf to interrupts and MFC.
    #1;
    check("to_first_mfa", ramMFA, 1);
    repeat (15) @(negedge clk);
    check("to_16th_mfa", ramMFA, 1);
    check("to_16th_buserr", busError, 0);
    @(negedge clk);
    check("to_err_mfa", ramMFA, 0);
    check("to_err_buserr", busError, 1);
    hardwareInterrupt = 1'b1; ramMFC = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", busError, 1);
    check("err_mfa", ramMFA, 0);
    check("err_irqack", irqAck, 0);
    check("err_pc", pc, 9'h000);
    hardwareInterrupt = 1'b0; ramMFC = 1'b0;
    reset = 1'b0;
    #1;
    check("err_reset_clear", busError, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("wb_queue_empty", wb_q.size(), 0);
    check("irq_queue_empty", irq_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
